minibyte_arb_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit registered arbitrating multiplexer.
- Unlike the combinational genmux family, the select is not driven externally. The select is derived internally by an arbiter that runs over per-channel valid/ready handshakes.
- A single registered output stage with valid/ready carries the selected data. It is used wherever several producers share one consumer (e.g. bus/memory-port sharing in the minibyte datapath).

---
 rtl/minibyte_mux_pkg.sv | 12 +
 rtl/minibyte_arbiter.sv | 42 ++++
 rtl/minibyte_arb_mux.sv | 77 +++++++
 tb/tb_minibyte_arb_mux.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/minibyte_mux_pkg.sv
// Shared constants and helpers for the minibyte arbitrating multiplexer family.
package minibyte_mux_pkg;

  localparam int MINIBYTE_ARB_FIXED = 0;
  localparam int MINIBYTE_ARB_RR    = 1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/minibyte_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round robin from a pointer.
module minibyte_arbiter
  import minibyte_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MODE   = MINIBYTE_ARB_RR,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_grant
);

  localparam bit IS_RR = (MODE == MINIBYTE_ARB_RR);

  // Both modes walk the ring once; fixed priority simply always starts at 0.
  always_comb begin
    int  base;
    int  ch;
    logic found;
    // NOTE: every variable gets a default before the search so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    base      = IS_RR ? int'(ptr) : 0;
    ch        = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      ch = base + off;
      if (ch >= NUM_CH) ch = ch - NUM_CH;
      if (!found && req[ch]) begin
        found     = 1'b1;
        grant[ch] = 1'b1;
        grant_idx = IDX_W'(ch);
      end
    end
  end

  assign any_grant = |req;

endmodule

// File: rtl/minibyte_arb_mux.sv
// N-channel registered arbitrating multiplexer with valid/ready on every side.
module minibyte_arb_mux
  import minibyte_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int MODE   = MINIBYTE_ARB_RR,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH*WIDTH-1:0] in_data_in,
  input  logic [NUM_CH-1:0]       in_valid_in,
  output logic [NUM_CH-1:0]       in_ready_out,
  output logic [WIDTH-1:0]        out_data_out,
  output logic                    out_valid_out,
  input  logic                    out_ready_in,
  output logic [IDX_W-1:0]        out_idx_out
);

  localparam bit IS_RR = (MODE == MINIBYTE_ARB_RR);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [NUM_CH-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              any_grant;
  logic              slot_free;
  logic              load;
  logic [WIDTH-1:0]  win_data;

  minibyte_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .req       (in_valid_in),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign slot_free = ~out_valid_out | out_ready_in;

  // Ready is forced low while reset is held, even though the slot looks free.
  assign in_ready_out = (rst_in || !slot_free || !any_grant) ? '0 : grant;
  assign load         = |(in_valid_in & in_ready_out);

  // AND-OR select on the one-hot grant keeps the data path free of a wide index multiply.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win_data = win_data | in_data_in[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_next = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_data_out  <= '0;
      out_idx_out   <= '0;
      out_valid_out <= 1'b0;
      rr_ptr        <= '0;
    end else if (load) begin
      out_data_out  <= win_data;
      out_idx_out   <= grant_idx;
      out_valid_out <= 1'b1;
      if (IS_RR) rr_ptr <= ptr_next;
    end else if (out_ready_in) begin
      out_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_minibyte_arb_mux.sv
// Directed bench: a fixed-priority and a round-robin instance share one stimulus stream.
module tb_minibyte_arb_mux;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] in_data_in;
  logic [3:0]  in_valid_in;
  logic        out_ready_in;

  logic [3:0]  fix_ready, rr_ready;
  logic [7:0]  fix_data, rr_data;
  logic        fix_valid, rr_valid;
  logic [1:0]  fix_idx, rr_idx;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  minibyte_arb_mux #(.WIDTH(8), .NUM_CH(4), .MODE(0)) u_fix (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_data_in    (in_data_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (fix_ready),
    .out_data_out  (fix_data),
    .out_valid_out (fix_valid),
    .out_ready_in  (out_ready_in),
    .out_idx_out   (fix_idx)
  );

  minibyte_arb_mux #(.WIDTH(8), .NUM_CH(4), .MODE(1)) u_rr (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_data_in    (in_data_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (rr_ready),
    .out_data_out  (rr_data),
    .out_valid_out (rr_valid),
    .out_ready_in  (out_ready_in),
    .out_idx_out   (rr_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [7:0] fdata, input logic [1:0] fidx,
                            input logic [7:0] rdata, input logic [1:0] ridx);
    check({tag, " fix valid"}, 32'(fix_valid), 1);
    check({tag, " fix data"},  32'(fix_data),  32'(fdata));
    check({tag, " fix idx"},   32'(fix_idx),   32'(fidx));
    check({tag, " rr valid"},  32'(rr_valid),  1);
    check({tag, " rr data"},   32'(rr_data),   32'(rdata));
    check({tag, " rr idx"},    32'(rr_idx),    32'(ridx));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every channel requesting.
    rst_in       = 1'b1;
    in_valid_in  = 4'b1111;
    in_data_in   = 32'h0;
    out_ready_in = 1'b1;
    #3;
    check("rst fix ready", 32'(fix_ready), 0);
    check("rst rr ready",  32'(rr_ready),  0);
    check("rst fix valid", 32'(fix_valid), 0);
    check("rst rr valid",  32'(rr_valid),  0);
    check("rst rr data",   32'(rr_data),   0);
    check("rst rr idx",    32'(rr_idx),    0);
    step();
    rst_in      = 1'b0;
    in_valid_in = 4'b0000;
    step();
    check("idle fix valid", 32'(fix_valid), 0);
    check("idle rr valid",  32'(rr_valid),  0);
    check("idle rr data",   32'(rr_data),   0);

    // Channels 1 and 3 requesting.
    in_data_in  = 32'h33_22_11_00;
    in_valid_in = 4'b1010;
    #1;
    check("pri fix ready", 32'(fix_ready), 'b0010);
    check("pri rr ready",  32'(rr_ready),  'b0010);
    step();
    check_both("pri1", 8'h11, 2'd1, 8'h11, 2'd1);
    check("pri fix ready again", 32'(fix_ready), 'b0010);
    check("pri rr ready ptr2",   32'(rr_ready),  'b1000);
    step();
    check_both("pri2", 8'h11, 2'd1, 8'h33, 2'd3);
    in_valid_in = 4'b1000;
    #1;
    check("pri fix ready ch3", 32'(fix_ready), 'b1000);
    step();
    check_both("pri3", 8'h33, 2'd3, 8'h33, 2'd3);

    // All channels valid: round robin rotates, fixed priority sticks to channel 0.
    in_data_in  = 32'hA3_A2_A1_A0;
    in_valid_in = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] e_idx;
      e_idx = 2'(k % 4);
      step();
      check_both("rr seq", 8'hA0, 2'd0, {6'b101000, e_idx}, e_idx);
    end

    // Backpressure: load 5C from channel 0, stall three cycles, then release.
    in_data_in  = 32'h00_00_00_5C;
    in_valid_in = 4'b0001;
    step();
    check_both("bp load", 8'h5C, 2'd0, 8'h5C, 2'd0);
    out_ready_in = 1'b0;
    in_data_in   = 32'h00_00_6D_5C;
    in_valid_in  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp fix ready", 32'(fix_ready), 0);
      check("bp rr ready",  32'(rr_ready),  0);
      step();
      check_both("bp stall", 8'h5C, 2'd0, 8'h5C, 2'd0);
    end
    out_ready_in = 1'b1;
    #1;
    check("bp release fix ready", 32'(fix_ready), 'b0010);
    check("bp release rr ready",  32'(rr_ready),  'b0010);
    step();
    check_both("bp next", 8'h6D, 2'd1, 8'h6D, 2'd1);

    // Drain and pointer hold: grant channel 2, idle two cycles, then 0 and 3 compete.
    in_data_in  = 32'h00_C2_00_00;
    in_valid_in = 4'b0100;
    step();
    check_both("drain load", 8'hC2, 2'd2, 8'hC2, 2'd2);
    in_valid_in = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      step();
      check("drain fix valid", 32'(fix_valid), 0);
      check("drain rr valid",  32'(rr_valid),  0);
      check("drain rr data",   32'(rr_data),   'hC2);
      check("drain rr idx",    32'(rr_idx),    2);
    end
    in_data_in  = 32'hD3_00_00_D0;
    in_valid_in = 4'b1001;
    #1;
    check("ptr fix ready", 32'(fix_ready), 'b0001);
    check("ptr rr ready",  32'(rr_ready),  'b1000);
    step();
    check_both("ptr hold", 8'hD0, 2'd0, 8'hD3, 2'd3);

    // Async reset in the middle of a stall.
    out_ready_in = 1'b0;
    in_valid_in  = 4'b0000;
    step();
    check("stall fix valid", 32'(fix_valid), 1);
    check("stall rr valid",  32'(rr_valid),  1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async fix valid", 32'(fix_valid), 0);
    check("async rr valid",  32'(rr_valid),  0);
    check("async rr data",   32'(rr_data),   0);
    check("async rr idx",    32'(rr_idx),    0);
    #1;
    rst_in       = 1'b0;
    in_data_in   = 32'hA3_A2_A1_A0;
    in_valid_in  = 4'b1111;
    out_ready_in = 1'b1;
    #1;
    check("post rst rr ready", 32'(rr_ready), 'b0001);
    step();
    check_both("post rst", 8'hA0, 2'd0, 8'hA0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
